gravsim_statefile: RTL and testbench

- Simulation state store that responds to the GravSim timestep FSM's write ports and to host software over an Avalon-MM slave port.
- Holds G, body count, start/done control words, and per-body mass, radius, position, velocity and acceleration as 32-bit words.
- Drives the full array combinationally to the FSM and owns the FSM_START/FSM_DONE run handshake.

---
 rtl/gravsim_statefile.sv | 188 ++++++++++++++++++
 tb/tb_gravsim_statefile.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gravsim_statefile.sv
// GravSim state file: word array shared by the timestep FSM and the host.
// Also owns the START/DONE run handshake and the STATUS word.
module gravsim_statefile #(
    parameter int NUM_WORDS  = 114,
    parameter int MAX_BODIES = 10,
    parameter int ACC_BASE   = 84,
    parameter int ACC_LEN    = 30
) (
    input  logic                       CLK,
    input  logic                       RESET,
    output logic [NUM_WORDS-1:0][31:0] datafile,
    input  logic                       clear_accs,
    input  logic [1:0]                 FSM_we,
    input  logic [31:0]                ADDR1,
    input  logic [31:0]                ADDR2,
    input  logic [31:0]                ADDR3,
    input  logic [31:0]                ADDR4,
    input  logic [31:0]                ADDR5,
    input  logic [31:0]                ADDR6,
    input  logic [31:0]                DATA1,
    input  logic [31:0]                DATA2,
    input  logic [31:0]                DATA3,
    input  logic [31:0]                DATA4,
    input  logic [31:0]                DATA5,
    input  logic [31:0]                DATA6,
    output logic                       FSM_START,
    input  logic                       FSM_DONE,
    input  logic                       AVL_CS,
    input  logic                       AVL_READ,
    input  logic                       AVL_WRITE,
    input  logic [6:0]                 AVL_ADDR,
    input  logic [31:0]                AVL_WRITEDATA,
    output logic [31:0]                AVL_READDATA
);

    localparam int WORD_NUM    = 1;
    localparam int WORD_START  = 2;
    localparam int WORD_STATUS = 3;
    localparam logic [6:0] LAST_WORD = 7'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } runState_t;

    runState_t runState;

    logic [NUM_WORDS-1:0][31:0] words;
    logic [NUM_WORDS-1:0][31:0] fsmData;
    logic [NUM_WORDS-1:0]       fsmHit;
    logic [NUM_WORDS-1:0]       hostSel;

    logic [31:0] portAddr [6];
    logic [31:0] portData [6];
    logic [5:0]  portEn;

    logic hostWr;
    logic hostRd;
    logic addrInRange;
    logic hostIsCtrl;
    logic hostGen;
    logic hostDrop;
    logic collide;
    logic startWr;
    logic statusClr;

    function automatic logic [31:0] clampNum(input logic [31:0] v);
        return (v > 32'(MAX_BODIES)) ? 32'(MAX_BODIES) : v;
    endfunction

    assign datafile = words;

    assign portAddr = '{ADDR1, ADDR2, ADDR3, ADDR4, ADDR5, ADDR6};
    assign portData = '{DATA1, DATA2, DATA3, DATA4, DATA5, DATA6};
    assign portEn   = {{3{FSM_we[1]}}, {3{FSM_we[0]}}};

    // Later ports overwrite earlier ones, so the highest-numbered hit wins.
    always_comb begin
        fsmHit  = '0;
        fsmData = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            for (int p = 0; p < 6; p++) begin
                if (portEn[p] && portAddr[p] == 32'(i) &&
                    i != WORD_START && i != WORD_STATUS) begin
                    fsmHit[i]  = 1'b1;
                    fsmData[i] = portData[p];
                end
            end
        end
    end

    assign hostWr      = AVL_CS & AVL_WRITE;
    assign hostRd      = AVL_CS & AVL_READ;
    assign addrInRange = AVL_ADDR <= LAST_WORD;
    assign hostIsCtrl  = AVL_ADDR == 7'(WORD_START) ||
                         AVL_ADDR == 7'(WORD_STATUS);
    assign startWr     = hostWr && AVL_ADDR == 7'(WORD_START);
    assign statusClr   = hostWr && AVL_ADDR == 7'(WORD_STATUS) &&
                         AVL_WRITEDATA[1];
    assign hostDrop    = hostWr && !hostIsCtrl && runState == RUN;
    assign hostGen     = hostWr && !hostIsCtrl && runState != RUN &&
                         addrInRange;
    assign collide     = hostWr && !hostIsCtrl && addrInRange &&
                         fsmHit[AVL_ADDR];

    always_comb begin
        hostSel = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            hostSel[i] = hostGen && AVL_ADDR == 7'(i);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            words        <= '0;
            runState     <= IDLE;
            FSM_START    <= 1'b0;
            AVL_READDATA <= '0;
        end else begin
            if (hostRd) begin
                AVL_READDATA <= addrInRange ? words[AVL_ADDR] : '0;
            end

            // FSM ports beat clear_accs, which beats the host.
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (i == WORD_START) begin
                    if (startWr) begin
                        words[i] <= AVL_WRITEDATA;
                    end
                end else if (i != WORD_STATUS) begin
                    if (fsmHit[i]) begin
                        words[i] <= (i == WORD_NUM) ?
                                    clampNum(fsmData[i]) : fsmData[i];
                    end else if (clear_accs && i >= ACC_BASE &&
                                 i < ACC_BASE + ACC_LEN) begin
                        words[i] <= '0;
                    end else if (hostSel[i]) begin
                        words[i] <= (i == WORD_NUM) ?
                                    clampNum(AVL_WRITEDATA) : AVL_WRITEDATA;
                    end
                end
            end

            if (statusClr) begin
                words[WORD_STATUS][1] <= 1'b0;
            end
            if (hostDrop || collide) begin
                words[WORD_STATUS][1] <= 1'b1;
            end

            unique case (runState)
                IDLE: begin
                    if (startWr && AVL_WRITEDATA[0]) begin
                        runState  <= RUN;
                        FSM_START <= 1'b1;
                    end
                end
                RUN: begin
                    if (startWr && !AVL_WRITEDATA[0]) begin
                        runState  <= IDLE;
                        FSM_START <= 1'b0;
                    end else if (FSM_DONE) begin
                        runState                     <= DONE;
                        words[WORD_STATUS][0]        <= 1'b1;
                        words[WORD_STATUS][31:16]    <=
                            words[WORD_STATUS][31:16] + 16'd1;
                    end
                end
                DONE: begin
                    if (startWr) begin
                        FSM_START <= AVL_WRITEDATA[0];
                    end
                    if (!FSM_DONE && !words[WORD_START][0]) begin
                        runState              <= IDLE;
                        FSM_START             <= 1'b0;
                        words[WORD_STATUS][0] <= 1'b0;
                    end
                end
                default: begin
                    runState  <= IDLE;
                    FSM_START <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gravsim_statefile.sv
// Directed bench for gravsim_statefile: spec-level model checked every
// cycle, plus hand-computed literal expectations.
module tb_gravsim_statefile;

    localparam int NW = 114;

    logic                CLK = 1'b0;
    logic                RESET;
    logic [NW-1:0][31:0] datafile;
    logic                clear_accs;
    logic [1:0]          FSM_we;
    logic [31:0]         ADDR1, ADDR2, ADDR3, ADDR4, ADDR5, ADDR6;
    logic [31:0]         DATA1, DATA2, DATA3, DATA4, DATA5, DATA6;
    logic                FSM_START;
    logic                FSM_DONE;
    logic                AVL_CS, AVL_READ, AVL_WRITE;
    logic [6:0]          AVL_ADDR;
    logic [31:0]         AVL_WRITEDATA;
    logic [31:0]         AVL_READDATA;

    int checks = 0;
    int errors = 0;
    bit checkOn = 1'b0;

    always #5 CLK = ~CLK;

    gravsim_statefile dut (
        .CLK(CLK), .RESET(RESET), .datafile(datafile),
        .clear_accs(clear_accs), .FSM_we(FSM_we),
        .ADDR1(ADDR1), .ADDR2(ADDR2), .ADDR3(ADDR3),
        .ADDR4(ADDR4), .ADDR5(ADDR5), .ADDR6(ADDR6),
        .DATA1(DATA1), .DATA2(DATA2), .DATA3(DATA3),
        .DATA4(DATA4), .DATA5(DATA5), .DATA6(DATA6),
        .FSM_START(FSM_START), .FSM_DONE(FSM_DONE),
        .AVL_CS(AVL_CS), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
        .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA),
        .AVL_READDATA(AVL_READDATA)
    );

    // Model: 0 idle, 1 run, 2 done; writes layered host, clear, ports 1..6.
    logic [31:0] mw [NW];
    logic [31:0] nw [NW];
    logic [31:0] pa [6];
    logic [31:0] pd [6];
    bit          pe [6];
    int          mState, mStep, ha;
    bit          mStart, mDone, mDrop, hw;
    logic [31:0] mRead, wd;

    always @(posedge CLK) begin
        if (RESET) begin
            foreach (mw[k]) mw[k] = 32'h0;
            mState = 0; mStep = 0; mStart = 0; mDone = 0; mDrop = 0;
            mRead = 32'h0;
        end else begin
            hw = AVL_CS && AVL_WRITE;
            ha = int'(AVL_ADDR);
            wd = AVL_WRITEDATA;
            if (AVL_CS && AVL_READ) mRead = (ha < NW) ? mw[ha] : 32'h0;
            foreach (mw[k]) nw[k] = mw[k];
            pa = '{ADDR1, ADDR2, ADDR3, ADDR4, ADDR5, ADDR6};
            pd = '{DATA1, DATA2, DATA3, DATA4, DATA5, DATA6};
            pe = '{FSM_we[0], FSM_we[0], FSM_we[0],
                   FSM_we[1], FSM_we[1], FSM_we[1]};
            if (hw && ha == 3 && wd[1]) mDrop = 0;
            if (hw && ha != 2 && ha != 3) begin
                if (mState == 1) mDrop = 1;
                else if (ha < NW)
                    nw[ha] = (ha == 1 && wd > 10) ? 32'd10 : wd;
            end
            if (clear_accs) for (int k = 84; k < 114; k++) nw[k] = 32'h0;
            for (int p = 0; p < 6; p++) begin
                if (pe[p] && pa[p] < NW && pa[p] != 2 && pa[p] != 3) begin
                    nw[pa[p]] = (pa[p] == 1 && pd[p] > 10) ? 32'd10 : pd[p];
                    if (hw && ha == int'(pa[p])) mDrop = 1;
                end
            end
            if (hw && ha == 2) nw[2] = wd;
            case (mState)
                0: if (hw && ha == 2 && wd[0]) begin
                    mState = 1; mStart = 1;
                end
                1: if (hw && ha == 2 && !wd[0]) begin
                    mState = 0; mStart = 0;
                end else if (FSM_DONE) begin
                    mState = 2; mDone = 1; mStep = (mStep + 1) % 65536;
                end
                default: begin
                    if (hw && ha == 2) mStart = wd[0];
                    if (!FSM_DONE && !mw[2][0]) begin
                        mState = 0; mDone = 0; mStart = 0;
                    end
                end
            endcase
            nw[3] = {mStep[15:0], 14'h0, mDrop, mDone};
            foreach (mw[k]) mw[k] = nw[k];
        end
    end

    int bad;
    always @(posedge CLK) begin
        #1;
        if (checkOn) begin
            bad = -1;
            for (int k = 0; k < NW; k++)
                if (datafile[k] !== mw[k] && bad < 0) bad = k;
            checks++;
            if (bad >= 0) begin
                errors++;
                $display("FAIL datafile[%0d] got %h want %h",
                         bad, datafile[bad], mw[bad]);
            end
            checks++;
            if (FSM_START !== mStart) begin
                errors++;
                $display("FAIL FSM_START got %b want %b", FSM_START, mStart);
            end
            checks++;
            if (AVL_READDATA !== mRead) begin
                errors++;
                $display("FAIL AVL_READDATA got %h want %h",
                         AVL_READDATA, mRead);
            end
        end
    end

    task automatic expect32(input string name, input logic [31:0] got,
                            input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic clearIn();
        clear_accs = 0; FSM_we = 0; FSM_DONE = 0;
        ADDR1 = 0; ADDR2 = 0; ADDR3 = 0; ADDR4 = 0; ADDR5 = 0; ADDR6 = 0;
        DATA1 = 0; DATA2 = 0; DATA3 = 0; DATA4 = 0; DATA5 = 0; DATA6 = 0;
        AVL_CS = 0; AVL_READ = 0; AVL_WRITE = 0;
        AVL_ADDR = 0; AVL_WRITEDATA = 0;
    endtask

    task automatic hostWrite(input logic [6:0] a, input logic [31:0] d);
        AVL_CS = 1; AVL_WRITE = 1; AVL_ADDR = a; AVL_WRITEDATA = d;
        tick();
        AVL_CS = 0; AVL_WRITE = 0;
    endtask

    task automatic hostRead(input logic [6:0] a);
        AVL_CS = 1; AVL_READ = 1; AVL_ADDR = a;
        tick();
        AVL_CS = 0; AVL_READ = 0;
    endtask

    initial begin
        clearIn();
        RESET = 1;
        tick();
        checkOn = 1;
        tick();
        RESET = 0;

        hostRead(7'd0);   expect32("rd0", AVL_READDATA, 32'h0);
        hostRead(7'd3);   expect32("rd3", AVL_READDATA, 32'h0);
        hostRead(7'd113); expect32("rd113", AVL_READDATA, 32'h0);
        expect32("startRst", {31'h0, FSM_START}, 32'h0);

        hostWrite(7'd1, 32'd25);
        hostRead(7'd1);   expect32("numClamp", AVL_READDATA, 32'd10);
        hostWrite(7'd4, 32'h3F800000);
        hostRead(7'd4);   expect32("rd4", AVL_READDATA, 32'h3F800000);
        hostRead(7'd120); expect32("rdOob", AVL_READDATA, 32'h0);

        AVL_CS = 1; AVL_READ = 1; AVL_WRITE = 1;
        AVL_ADDR = 7'd4; AVL_WRITEDATA = 32'h11111111;
        tick();
        clearIn();
        expect32("rdOld", AVL_READDATA, 32'h3F800000);
        expect32("wrNew", datafile[4], 32'h11111111);

        FSM_we = 2'd3;
        ADDR1 = 84; DATA1 = 32'h40000000;
        ADDR2 = 200; DATA2 = 32'hDEADBEEF;
        ADDR3 = 84; DATA3 = 32'h1;
        ADDR4 = 84; DATA4 = 32'h2;
        ADDR5 = 84; DATA5 = 32'h3;
        ADDR6 = 84; DATA6 = 32'h40400000;
        tick();
        clearIn();
        expect32("portPrio", datafile[84], 32'h40400000);

        FSM_we = 2'd2; ADDR4 = 1; DATA4 = 99; ADDR5 = 200; ADDR6 = 200;
        tick();
        clearIn();
        expect32("fsmNumClamp", datafile[1], 32'd10);

        FSM_we = 2'd1; ADDR1 = 10; DATA1 = 32'hA;
        ADDR2 = 200; ADDR3 = 200; ADDR4 = 11; DATA4 = 32'hB;
        tick();
        clearIn();
        expect32("grpLo", datafile[10], 32'hA);
        expect32("grpHiOff", datafile[11], 32'h0);

        for (int k = 84; k < 114; k++) hostWrite(7'(k), 32'h3F800000);
        hostWrite(7'd83, 32'h12345678);
        clear_accs = 1; FSM_we = 2'd1;
        ADDR1 = 90; DATA1 = 32'h41200000; ADDR2 = 200; ADDR3 = 200;
        tick();
        clearIn();
        expect32("clr90", datafile[90], 32'h41200000);
        expect32("clr84", datafile[84], 32'h0);
        expect32("clr113", datafile[113], 32'h0);
        expect32("keep83", datafile[83], 32'h12345678);

        AVL_CS = 1; AVL_WRITE = 1; AVL_ADDR = 7'd20; AVL_WRITEDATA = 32'h1;
        FSM_we = 2'd1; ADDR1 = 20; DATA1 = 32'h2; ADDR2 = 200; ADDR3 = 200;
        tick();
        clearIn();
        expect32("collideWord", datafile[20], 32'h2);
        expect32("collideFlag", datafile[3], 32'h2);
        hostWrite(7'd3, 32'h2);
        expect32("flagClr", datafile[3], 32'h0);

        hostWrite(7'd2, 32'h1);
        expect32("startRun", {31'h0, FSM_START}, 32'h1);
        hostWrite(7'd5, 32'h55);
        expect32("dropWord", datafile[5], 32'h0);
        expect32("dropFlag", datafile[3], 32'h00000002);
        FSM_DONE = 1;
        tick();
        FSM_DONE = 0;
        expect32("doneStatus", datafile[3], 32'h00010003);
        tick();
        expect32("startHeld", {31'h0, FSM_START}, 32'h1);
        hostWrite(7'd2, 32'h0);
        expect32("startDrop", {31'h0, FSM_START}, 32'h0);
        tick();
        expect32("doneClr", datafile[3], 32'h00010002);
        hostWrite(7'd5, 32'h55);
        expect32("idleWrite", datafile[5], 32'h55);

        hostWrite(7'd3, 32'h2);
        hostWrite(7'd2, 32'h1);
        expect32("rerun", {31'h0, FSM_START}, 32'h1);
        hostWrite(7'd2, 32'h0);
        expect32("abortStart", {31'h0, FSM_START}, 32'h0);
        expect32("abortStep", datafile[3], 32'h00010000);

        hostWrite(7'd2, 32'h1);
        tick();
        RESET = 1;
        tick();
        RESET = 0;
        expect32("rstStart", {31'h0, FSM_START}, 32'h0);
        expect32("rstStatus", datafile[3], 32'h0);
        expect32("rstAll", {31'h0, |datafile}, 32'h0);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
